// File: rtl/muldiv_seq_pkg.sv
// Shared opsel codes, register width and sequencer state encoding for the
// multi-cycle multiply/divide unit.
package muldiv_seq_pkg;

  localparam int REG_WIDTH = 32;

  localparam logic [2:0] ALU_MUL_L = 3'b010;
  localparam logic [2:0] ALU_MUL_H = 3'b011;
  localparam logic [2:0] ALU_DIV   = 3'b100;
  localparam logic [2:0] ALU_REM   = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/muldiv_div_step.sv
// One radix-2 restoring division iteration: shift {rem,quo} left by one and
// subtract the divisor when it fits.
module muldiv_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH-1:0] w_diff;
  logic             w_fits;

  // rem < b holds on entry, so the shifted remainder needs one extra bit and
  // the difference always fits back into WIDTH bits.
  assign w_rem_sh = {i_rem, i_quo[WIDTH-1]};
  assign w_fits   = (w_rem_sh >= {1'b0, i_b});
  assign w_diff   = w_rem_sh[WIDTH-1:0] - i_b;

  assign o_rem = w_fits ? w_diff : w_rem_sh[WIDTH-1:0];
  assign o_quo = {i_quo[WIDTH-2:0], w_fits};

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle multiply/divide sequencer beside the EX stage: one-cycle
// registered product, WIDTH-cycle restoring divide, valid/ready handshake.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int WIDTH = REG_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_ovf,
  output logic             resp_cf,
  output logic             busy
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_sel;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_result;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_is_mul;
  logic               w_is_div;
  logic               w_b_zero;
  logic               w_last;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_rem_nxt;
  logic [WIDTH-1:0]   w_quo_nxt;

  assign w_is_mul = (req_op == ALU_MUL_L) || (req_op == ALU_MUL_H);
  assign w_is_div = (req_op == ALU_DIV) || (req_op == ALU_REM);
  assign w_b_zero = (req_b == '0);
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));
  // r_quo doubles as the multiplicand register during MUL.
  assign w_prod   = (2*WIDTH)'(r_quo) * (2*WIDTH)'(r_b);

  muldiv_div_step #(.WIDTH(WIDTH)) u_div_step (
    .i_rem (r_rem),
    .i_quo (r_quo),
    .i_b   (r_b),
    .o_rem (w_rem_nxt),
    .o_quo (w_quo_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: if (req_valid) begin
          if (w_is_mul)                   w_state_nxt = MUL;
          else if (w_is_div && !w_b_zero) w_state_nxt = DIV;
          else                            w_state_nxt = DONE;
        end
        MUL:     w_state_nxt = DONE;
        DIV:     if (w_last) w_state_nxt = DONE;
        DONE:    if (resp_ready) w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel    <= 1'b0;
      r_quo    <= '0;
      r_rem    <= '0;
      r_b      <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else if (!flush) begin
      case (r_state)
        IDLE: if (req_valid) begin
          r_sel <= req_op[0];
          r_quo <= req_a;
          r_b   <= req_b;
          r_rem <= '0;
          r_cnt <= '0;
          if (w_is_div && w_b_zero)   r_result <= req_op[0] ? req_a : '1;
          else if (!w_is_mul && !w_is_div) r_result <= '0;
        end
        MUL: r_result <= r_sel ? w_prod[2*WIDTH-1:WIDTH] : w_prod[WIDTH-1:0];
        DIV: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) r_result <= r_sel ? w_rem_nxt : w_quo_nxt;
        end
        default: ;
      endcase
    end
  end

  assign req_ready   = (r_state == IDLE);
  assign busy        = (r_state != IDLE);
  assign resp_valid  = (r_state == DONE);
  assign resp_result = r_result;
  assign resp_ovf    = 1'b0;
  assign resp_cf     = 1'b0;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed and randomized checks of muldiv_seq against a plain-arithmetic
// model of the unsigned multiply/divide results and their latencies.
module tb_muldiv_seq;
  import muldiv_seq_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         flush = 1'b0;
  logic         req_valid = 1'b0;
  logic         resp_ready = 1'b1;
  logic [2:0]   req_op = 3'b000;
  logic [W-1:0] req_a = '0;
  logic [W-1:0] req_b = '0;
  logic         req_ready;
  logic         resp_valid;
  logic [W-1:0] resp_result;
  logic         resp_ovf;
  logic         resp_cf;
  logic         busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  muldiv_seq #(.WIDTH(W), .CNT_W(6)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .resp_ovf    (resp_ovf),
    .resp_cf     (resp_cf),
    .busy        (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] model_result(input logic [2:0] op,
                                                input logic [W-1:0] a,
                                                input logic [W-1:0] b);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    case (op)
      ALU_MUL_L: return p[W-1:0];
      ALU_MUL_H: return p[2*W-1:W];
      ALU_DIV:   return (b == 0) ? {W{1'b1}} : a / b;
      ALU_REM:   return (b == 0) ? a : a % b;
      default:   return '0;
    endcase
  endfunction

  // Edges after the accept edge until resp_valid rises.
  function automatic int model_lat(input logic [2:0] op, input logic [W-1:0] b);
    if (op == ALU_MUL_L || op == ALU_MUL_H) return 1;
    if (op == ALU_DIV || op == ALU_REM) return (b == 0) ? 0 : W;
    return 0;
  endfunction

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_op    = 3'($urandom);
    req_a     = $urandom;
    req_b     = $urandom;
  endtask

  task automatic wait_resp(output int n, output bit stall_ok);
    n = 0;
    stall_ok = 1'b1;
    while (resp_valid !== 1'b1 && n < 100) begin
      if (req_ready !== 1'b0 || busy !== 1'b1) stall_ok = 1'b0;
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp, input string tag);
    int n;
    bit stall_ok;
    issue(op, a, b);
    wait_resp(n, stall_ok);
    chk({tag, "_lat"}, 64'(n), 64'(model_lat(op, b)));
    chk({tag, "_res"}, 64'(resp_result), 64'(exp));
    chk({tag, "_flags"}, {62'd0, resp_ovf, resp_cf}, 64'd0);
    chk({tag, "_stall"}, {61'd0, stall_ok, busy, req_ready}, 64'b110);
    @(posedge clk); #1;
    chk({tag, "_idle"}, {61'd0, resp_valid, req_ready, busy}, 64'b010);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           n;
    bit           stall_ok;
    bit           saw;

    #2 rst_n = 1'b0;
    #1;
    chk("reset_out", {27'd0, req_ready, resp_valid, busy, resp_ovf, resp_cf, resp_result},
        {27'd0, 5'b10000, 32'd0});
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    run_op(ALU_MUL_L, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, "mul_l");
    run_op(ALU_MUL_H, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, "mul_h");
    run_op(ALU_DIV, 32'd100, 32'd7, 32'd14, "div");
    run_op(ALU_REM, 32'd100, 32'd7, 32'd2, "rem");
    run_op(ALU_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, "div0");
    run_op(ALU_REM, 32'd5, 32'd0, 32'd5, "rem0");
    run_op(3'b000, 32'd9, 32'd3, 32'd0, "op000");
    run_op(3'b111, 32'd9, 32'd3, 32'd0, "op111");

    // Back-pressure: result must stay put while resp_ready is low.
    resp_ready = 1'b0;
    issue(ALU_MUL_L, 32'd3, 32'd4);
    wait_resp(n, stall_ok);
    chk("bp_lat", 64'(n), 64'd1);
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_hold", {31'd0, resp_valid, resp_result}, {31'd0, 1'b1, 32'd12});
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", {61'd0, resp_valid, req_ready, busy}, 64'b010);
    run_op(ALU_MUL_H, 32'hFFFF_FFFF, 32'd2, 32'd1, "bp_next");

    // Flush at iteration 10 of a divide, with a competing request.
    issue(ALU_DIV, 32'd100000, 32'd3);
    saw = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (resp_valid) saw = 1'b1;
    end
    flush     = 1'b1;
    req_valid = 1'b1;
    req_op    = ALU_MUL_L;
    @(posedge clk); #1;
    flush     = 1'b0;
    req_valid = 1'b0;
    chk("flush_idle", {61'd0, resp_valid, req_ready, busy}, 64'b010);
    repeat (40) begin
      @(posedge clk); #1;
      if (resp_valid || busy) saw = 1'b1;
    end
    chk("flush_nores", 64'(saw), 64'd0);
    run_op(ALU_MUL_L, 32'd6, 32'd7, 32'd42, "flush_next");

    // Asynchronous reset between edges mid-divide.
    issue(ALU_DIV, 32'hDEAD_BEEF, 32'd7);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out", {27'd0, req_ready, resp_valid, busy, resp_ovf, resp_cf, resp_result},
        {27'd0, 5'b10000, 32'd0});
    @(posedge clk); #1;
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (resp_valid || busy) saw = 1'b1;
    end
    chk("arst_nores", 64'(saw), 64'd0);
    run_op(ALU_DIV, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, "div_big");

    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : 32'($urandom);
      case ($urandom_range(0, 3))
        0:       b = '0;
        1:       b = 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      run_op(op, a, b, model_result(op, a, b), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
